counter_bank: RTL and testbench

Parametrised multi-channel timer/counter bank, the successor to the three-channel fixed-width counter block. It provides NCH independent down/up counters of WIDTH bits, each clocked by an external tick source, with four operating modes, sticky terminal flags and a combined interrupt. It sits on the CPU's memory-mapped I/O bus next to the other peripherals. Its per-channel outputs drive timing and interrupt logic.

---
 rtl/counter_bank.sv | 212 +++++++++++++++++++++
 tb/tb_counter_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// counter_bank: NCH independent WIDTH-bit timer/counter channels on the
// memory-mapped I/O bus. Each channel counts ticks from its own tick_in
// source in one of four modes (one-shot, rate, square, event). It keeps a
// sticky terminal flag and contributes to a combined interrupt.
//
// Optional build macro: COUNTER_BANK_SYNC_EN
//   defined   - each tick_in passes through a 2-flop synchroniser and a
//               rising-edge detector (count updates on the 3rd clk edge
//               after tick_in rises).
//   undefined - tick_in is a synchronous level enable (one tick per clk
//               edge while high).
//
// Ports:
//   clk      system clock, all state on rising edge
//   reset    asynchronous, active-low reset
//   tick_in  per-channel count sources
//   we       register write strobe
//   ch       channel select (values >= NCH are unmapped)
//   sel      register select: 0 reload, 1 ctrl, 2 status, 3 count
//   wdata    write data
//   rdata    registered read data
//   cnt_out  per-channel output waveform
//   irq      OR over channels of (flag & irq_en)
module counter_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   tick_in,
    input  logic             we,
    input  logic [2:0]       ch,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [NCH-1:0]   cnt_out,
    output logic             irq
);

    localparam logic [1:0] SEL_RELOAD = 2'd0;
    localparam logic [1:0] SEL_CTRL   = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_COUNT  = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RATE    = 2'd1;
    localparam logic [1:0] MODE_SQUARE  = 2'd2;
    localparam logic [1:0] MODE_EVENT   = 2'd3;

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [NCH-1:0] tick;

`ifdef COUNTER_BANK_SYNC_EN
    logic [NCH-1:0] sync_p0;
    logic [NCH-1:0] sync_p1;
    logic [NCH-1:0] sync_p2;

    // synchroniser stages p0/p1, p2 holds the previous level for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p0 <= tick_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign tick = sync_p1 & ~sync_p2;
`else
    assign tick = tick_in;
`endif

    logic [WIDTH-1:0] count_q  [NCH];
    logic [WIDTH-1:0] reload_q [NCH];
    logic [1:0]       mode_q   [NCH];
    logic [NCH-1:0]   en_q;
    logic [NCH-1:0]   ie_q;
    logic [NCH-1:0]   flag_q;
    logic [NCH-1:0]   out_q;

    logic [31:0]      ch_idx;
    logic [NCH-1:0]   hit;
    logic [NCH-1:0]   tick_ok;
    logic [WIDTH-1:0] rd_next;

    assign ch_idx = 32'(ch);

    // A write to reload/ctrl/count drops a coincident tick; a status write
    // does not, so a terminal event can still set the flag over a clear.
    always_comb begin
        hit     = '0;
        tick_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i]     = we && (ch_idx == 32'(i));
            tick_ok[i] = tick[i] && en_q[i] && !(hit[i] && (sel != SEL_STATUS));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
                mode_q[i]   <= '0;
            end
            en_q   <= '0;
            ie_q   <= '0;
            flag_q <= '0;
            out_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // modes 1 and 3 (mode bit 0 set) drive one-clk pulses only
                if (mode_q[i][0]) begin
                    out_q[i] <= 1'b0;
                end

                if (hit[i]) begin
                    case (sel)
                        SEL_RELOAD: begin
                            reload_q[i] <= wdata;
                            count_q[i]  <= wdata;
                            if (!mode_q[i][0]) begin
                                out_q[i] <= 1'b0;
                            end
                        end
                        SEL_CTRL: begin
                            mode_q[i] <= wdata[1:0];
                            en_q[i]   <= wdata[2];
                            ie_q[i]   <= wdata[3];
                        end
                        SEL_STATUS: begin
                            if (wdata[0]) begin
                                flag_q[i] <= 1'b0;
                            end
                        end
                        SEL_COUNT: begin
                            count_q[i] <= wdata;
                        end
                        default: ;
                    endcase
                end

                // placed after the write decode so a terminal set beats a clear
                if (tick_ok[i]) begin
                    if (mode_q[i] == MODE_EVENT) begin
                        if (count_q[i] == ONES) begin
                            count_q[i] <= '0;
                            out_q[i]   <= 1'b1;
                            flag_q[i]  <= 1'b1;
                        end else begin
                            count_q[i] <= count_q[i] + ONE;
                        end
                    end else if (count_q[i] == ONE) begin
                        flag_q[i] <= 1'b1;
                        case (mode_q[i])
                            MODE_ONESHOT: begin
                                count_q[i] <= '0;
                                out_q[i]   <= 1'b1;
                            end
                            MODE_RATE: begin
                                count_q[i] <= reload_q[i];
                                out_q[i]   <= 1'b1;
                            end
                            MODE_SQUARE: begin
                                count_q[i] <= reload_q[i];
                                out_q[i]   <= ~out_q[i];
                            end
                            default: ;
                        endcase
                    end else if (count_q[i] != '0) begin
                        // a zero count is a halted channel
                        count_q[i] <= count_q[i] - ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == 32'(i)) begin
                case (sel)
                    SEL_RELOAD: rd_next = reload_q[i];
                    SEL_CTRL:   rd_next[3:0] = {ie_q[i], en_q[i], mode_q[i]};
                    SEL_STATUS: rd_next[2:0] = {en_q[i] && ((count_q[i] != '0) ||
                                                (mode_q[i] == MODE_EVENT)),
                                                out_q[i], flag_q[i]};
                    SEL_COUNT:  rd_next = count_q[i];
                    default:    rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            rdata <= rd_next;
        end
    end

    assign cnt_out = out_q;
    assign irq     = |(flag_q & ie_q);

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank (NCH=4, WIDTH=32). Register reads go
// through a scoreboard queue: the expected value is pushed when ch/sel are
// driven and popped when the registered rdata appears a cycle later.
module tb_counter_bank;

    localparam int NCH   = 4;
    localparam int WIDTH = 32;

    localparam logic [1:0] S_RELOAD = 2'd0;
    localparam logic [1:0] S_CTRL   = 2'd1;
    localparam logic [1:0] S_STATUS = 2'd2;
    localparam logic [1:0] S_COUNT  = 2'd3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NCH-1:0]   tick_in = '0;
    logic             we = 1'b0;
    logic [2:0]       ch = '0;
    logic [1:0]       sel = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] rdata;
    logic [NCH-1:0]   cnt_out;
    logic             irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];

    int hi_cnt   [NCH] = '{default: 0};
    int rise_cnt [NCH] = '{default: 0};
    logic [NCH-1:0] prev_out = '0;

    counter_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick_in (tick_in),
        .we      (we),
        .ch      (ch),
        .sel     (sel),
        .wdata   (wdata),
        .rdata   (rdata),
        .cnt_out (cnt_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // pulse monitor: samples cnt_out away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (cnt_out[i]) hi_cnt[i]++;
            if (cnt_out[i] && !prev_out[i]) rise_cnt[i]++;
        end
        prev_out = cnt_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] c, input logic [1:0] s, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; ch = c; sel = s; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] c, input logic [1:0] s, input logic [31:0] e,
                      input string tag);
        logic [31:0] popped;
        @(negedge clk);
        ch = c; sel = s;
        exp_q.push_back(e);
        @(negedge clk);
        popped = exp_q.pop_front();
        chk(tag, rdata, popped);
    endtask

    task automatic tick(input int c);
`ifdef COUNTER_BANK_SYNC_EN
        @(negedge clk);
        tick_in[c] = 1'b1;
        repeat (2) @(negedge clk);
        tick_in[c] = 1'b0;
        repeat (2) @(negedge clk);
`else
        @(negedge clk);
        tick_in[c] = 1'b1;
        @(negedge clk);
        tick_in[c] = 1'b0;
`endif
    endtask

    // register write landing on the same clk edge that processes a tick
    task automatic tick_with_write(input int c, input logic [1:0] s, input logic [31:0] d);
`ifdef COUNTER_BANK_SYNC_EN
        @(negedge clk);
        tick_in[c] = 1'b1;
        repeat (2) @(negedge clk);
        tick_in[c] = 1'b0;
        we = 1'b1; ch = 3'(c); sel = s; wdata = d;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
`else
        @(negedge clk);
        tick_in[c] = 1'b1;
        we = 1'b1; ch = 3'(c); sel = s; wdata = d;
        @(negedge clk);
        tick_in[c] = 1'b0;
        we = 1'b0;
`endif
    endtask

    initial begin
        int r0, h0;
        logic [31:0] seq_rate [9];
        seq_rate = '{32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_cnt_out", {28'h0, cnt_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;

        // mid-operation reset
        wr(3'd0, S_CTRL, 32'hD);
        wr(3'd0, S_RELOAD, 32'd2);
        tick(0);
        tick(0);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        rd(3'd0, S_STATUS, 32'h5, "pre_rst_status");
        #3 reset = 1'b0;
        #1;
        chk("async_rst_rdata", rdata, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        chk("async_rst_cnt_out", {28'h0, cnt_out}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd(3'd0, S_COUNT, 32'h0, "post_rst_count");
        rd(3'd0, S_CTRL, 32'h0, "post_rst_ctrl");
        for (int k = 0; k < 10; k++) tick(0);
        rd(3'd0, S_COUNT, 32'h0, "disabled_ticks_count");
        rd(3'd0, S_STATUS, 32'h0, "disabled_ticks_status");

        // one-shot on ch1
        wr(3'd1, S_CTRL, 32'hC);
        wr(3'd1, S_RELOAD, 32'd5);
        rd(3'd1, S_CTRL, 32'hC, "oneshot_ctrl");
        rd(3'd1, S_COUNT, 32'd5, "oneshot_loaded");
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            rd(3'd1, S_COUNT, (k < 5) ? 32'(5 - k) : 32'd0, "oneshot_count");
            if (k == 5) begin
                chk("oneshot_cnt_out", {31'h0, cnt_out[1]}, 32'h1);
                chk("oneshot_irq", {31'h0, irq}, 32'h1);
            end
        end
        rd(3'd1, S_STATUS, 32'h3, "oneshot_status");
        wr(3'd1, S_STATUS, 32'h1);
        chk("oneshot_clr_irq", {31'h0, irq}, 32'h0);
        chk("oneshot_clr_cnt_out", {31'h0, cnt_out[1]}, 32'h1);
        rd(3'd1, S_STATUS, 32'h2, "oneshot_status_cleared");

        // rate on ch0
        wr(3'd0, S_CTRL, 32'h5);
        wr(3'd0, S_RELOAD, 32'd3);
        r0 = rise_cnt[0];
        h0 = hi_cnt[0];
        for (int k = 0; k < 9; k++) begin
            tick(0);
            rd(3'd0, S_COUNT, seq_rate[k], "rate_count");
        end
        chk("rate_pulses", 32'(rise_cnt[0] - r0), 32'd3);
        chk("rate_pulse_width", 32'(hi_cnt[0] - h0), 32'd3);
        rd(3'd0, S_STATUS, 32'h5, "rate_status");

        // square on ch2
        wr(3'd2, S_CTRL, 32'h6);
        wr(3'd2, S_RELOAD, 32'd10);
        for (int k = 1; k <= 40; k++) begin
            tick(2);
            if (k == 5) chk("square_early", {31'h0, cnt_out[2]}, 32'h0);
            if (k % 10 == 0) chk("square_toggle", {31'h0, cnt_out[2]}, 32'((k / 10) % 2));
        end
        rd(3'd2, S_COUNT, 32'd10, "square_count");

        // reload of zero halts the channel
        wr(3'd2, S_RELOAD, 32'd0);
        for (int k = 0; k < 3; k++) tick(2);
        rd(3'd2, S_COUNT, 32'd0, "halted_count");
        chk("halted_cnt_out", {31'h0, cnt_out[2]}, 32'h0);

        // event counter with wrap on ch3
        wr(3'd3, S_CTRL, 32'h7);
        wr(3'd3, S_RELOAD, 32'hFFFF_FFFE);
        r0 = rise_cnt[3];
        h0 = hi_cnt[3];
        tick(3);
        rd(3'd3, S_COUNT, 32'hFFFF_FFFF, "event_count_ones");
        tick(3);
        rd(3'd3, S_COUNT, 32'h0, "event_wrap");
        tick(3);
        rd(3'd3, S_COUNT, 32'h1, "event_after_wrap");
        chk("event_pulses", 32'(rise_cnt[3] - r0), 32'd1);
        chk("event_pulse_width", 32'(hi_cnt[3] - h0), 32'd1);
        rd(3'd3, S_STATUS, 32'h5, "event_status");

        // collision: status clear vs terminal event (ch0 mode 1, count 3)
        wr(3'd0, S_STATUS, 32'h1);
        rd(3'd0, S_STATUS, 32'h4, "coll_flag_cleared");
        tick(0);
        tick(0);
        rd(3'd0, S_COUNT, 32'd1, "coll_pre_terminal");
        tick_with_write(0, S_STATUS, 32'h1);
        rd(3'd0, S_STATUS, 32'h5, "coll_set_wins");
        rd(3'd0, S_COUNT, 32'd3, "coll_terminal_reload");

        // collision: reload write vs tick
        tick_with_write(0, S_RELOAD, 32'd7);
        rd(3'd0, S_COUNT, 32'd7, "coll_reload_wins");

        // unmapped channel
        wr(3'd5, S_RELOAD, 32'h55);
        wr(3'd5, S_CTRL, 32'hF);
        rd(3'd5, S_RELOAD, 32'h0, "unmapped_reload");
        rd(3'd5, S_CTRL, 32'h0, "unmapped_ctrl");
        rd(3'd0, S_RELOAD, 32'd7, "unmapped_no_side_effect");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
